alu_issue_queue: RTL and testbench

//  In-order holding queue between the decoder and the ALU reservation station (RS).

---
 rtl/alu_issue_queue.sv | 153 +++++++++++++++
 tb/tb_alu_issue_queue.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_queue.sv
// In-order holding queue between the decoder and the ALU reservation station.
// Decoded ops wait here while every RS entry is busy. Both CDBs are snooped so
// that waiting operands are already resolved when an op finally enters the RS.
// When the queue is empty and the RS has room, an op bypasses the storage with
// zero latency.
module alu_issue_queue #(
   parameter int DATA_W   = 32,
   parameter int TAG_W    = 5,
   parameter int OP_W     = 4,
   parameter int NOP      = 0,
   parameter int TAG_FREE = 0,
   parameter int DEPTH    = 4,
   parameter int RS_SIZE  = 8,
   parameter int INST_W   = OP_W + 2*DATA_W + 3*TAG_W,
   parameter int CNT_W    = $clog2(DEPTH) + 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   input  logic [INST_W-1:0] in_inst,
   output logic              in_ready,
   input  logic [RS_SIZE-1:0] rs_free_state,
   output logic              out_enable,
   output logic [INST_W-1:0] out_inst,
   input  logic              lsb_cdb_valid,
   input  logic [TAG_W-1:0]  lsb_cdb_tag,
   input  logic [DATA_W-1:0] lsb_cdb_data,
   input  logic              alu_cdb_valid,
   input  logic [TAG_W-1:0]  alu_cdb_tag,
   input  logic [DATA_W-1:0] alu_cdb_data,
   output logic [CNT_W-1:0]  count
);

   localparam int PTR_W  = $clog2(DEPTH);
   // Field offsets inside an entry {dest,tag2,data2,tag1,data1,op}
   localparam int D1_LSB = OP_W;
   localparam int T1_LSB = D1_LSB + DATA_W;
   localparam int D2_LSB = T1_LSB + TAG_W;
   localparam int T2_LSB = D2_LSB + DATA_W;

   localparam logic [OP_W-1:0]  NOP_C      = OP_W'(NOP);
   localparam logic [TAG_W-1:0] TAG_FREE_C = TAG_W'(TAG_FREE);
   localparam logic [CNT_W-1:0] DEPTH_C    = CNT_W'(DEPTH);

   logic [INST_W-1:0] mem_reg [0:DEPTH-1];
   logic [PTR_W-1:0]  head_reg;
   logic [PTR_W-1:0]  tail_reg;
   logic [CNT_W-1:0]  count_reg;

   // Index DEPTH carries the incoming op; 0..DEPTH-1 are the stored entries.
   logic [INST_W-1:0] src_inst [0:DEPTH];
   logic [INST_W-1:0] fwd_inst [0:DEPTH];

   logic rs_has_free;
   logic push_cand;
   logic count_nz;
   logic kill;
   logic pop;
   logic wr;

   genvar gi;
   generate
      for (gi = 0; gi <= DEPTH; gi++) begin : g_fwd
         logic [INST_W-1:0] f;
         logic [TAG_W-1:0]  t1;
         logic [TAG_W-1:0]  t2;

         if (gi < DEPTH) begin : g_mem
            assign src_inst[gi] = mem_reg[gi];
         end else begin : g_in
            assign src_inst[gi] = in_inst;
         end

         assign t1 = src_inst[gi][T1_LSB +: TAG_W];
         assign t2 = src_inst[gi][T2_LSB +: TAG_W];

         // Resolve each waiting operand from the CDBs; the LSB CDB has priority.
         always_comb begin
            f = src_inst[gi];
            if (t1 != TAG_FREE_C) begin
               if (lsb_cdb_valid && lsb_cdb_tag == t1) begin
                  f[D1_LSB +: DATA_W] = lsb_cdb_data;
                  f[T1_LSB +: TAG_W]  = TAG_FREE_C;
               end else if (alu_cdb_valid && alu_cdb_tag == t1) begin
                  f[D1_LSB +: DATA_W] = alu_cdb_data;
                  f[T1_LSB +: TAG_W]  = TAG_FREE_C;
               end
            end
            if (t2 != TAG_FREE_C) begin
               if (lsb_cdb_valid && lsb_cdb_tag == t2) begin
                  f[D2_LSB +: DATA_W] = lsb_cdb_data;
                  f[T2_LSB +: TAG_W]  = TAG_FREE_C;
               end else if (alu_cdb_valid && alu_cdb_tag == t2) begin
                  f[D2_LSB +: DATA_W] = alu_cdb_data;
                  f[T2_LSB +: TAG_W]  = TAG_FREE_C;
               end
            end
         end

         assign fwd_inst[gi] = f;
      end
   endgenerate

   assign rs_has_free = ~&rs_free_state;
   assign push_cand   = in_valid && (in_inst[OP_W-1:0] != NOP_C);
   assign count_nz    = (count_reg != '0);
   assign kill        = rst || flush;
   assign in_ready    = (count_reg < DEPTH_C);
   assign count       = count_reg;

   // Issue head entry if any, else bypass the incoming op straight to the RS.
   always_comb begin
      out_enable = 1'b0;
      out_inst   = '0;
      pop        = 1'b0;
      wr         = 1'b0;
      if (!kill) begin
         out_enable = rs_has_free && (count_nz || push_cand);
         out_inst   = count_nz ? fwd_inst[{1'b0, head_reg}] : fwd_inst[DEPTH];
         pop        = out_enable && count_nz;
         // A bypassed op goes directly to the RS and is not stored.
         wr         = push_cand && in_ready && !(out_enable && !count_nz);
      end
   end

   // Pointer and occupancy bookkeeping.
   always_ff @(posedge clk) begin
      if (kill) begin
         head_reg  <= '0;
         tail_reg  <= '0;
         count_reg <= '0;
      end else begin
         if (pop) head_reg <= head_reg + PTR_W'(1);
         if (wr)  tail_reg <= tail_reg + PTR_W'(1);
         count_reg <= count_reg + CNT_W'(wr) - CNT_W'(pop);
      end
   end

   // Entry storage: snoop live entries, retire the popped head, write new op.
   always_ff @(posedge clk) begin
      if (kill) begin
         for (int i = 0; i < DEPTH; i++) mem_reg[i] <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (mem_reg[i][OP_W-1:0] != NOP_C) mem_reg[i] <= fwd_inst[i];
         end
         if (pop) mem_reg[head_reg][OP_W-1:0] <= NOP_C;
         if (wr)  mem_reg[tail_reg] <= fwd_inst[DEPTH];
      end
   end

endmodule

// File: tb/tb_alu_issue_queue.sv
// Scoreboard bench for alu_issue_queue: a queue-based reference model predicts
// every issued op; a separate monitor compares what the DUT presents.
module tb_alu_issue_queue;

   localparam int DATA_W = 32;
   localparam int TAG_W  = 5;
   localparam int OP_W   = 4;
   localparam int DEPTH  = 4;
   localparam int INST_W = OP_W + 2*DATA_W + 3*TAG_W;
   localparam int CNT_W  = $clog2(DEPTH) + 1;

   typedef struct packed {
      logic [TAG_W-1:0]  dest;
      logic [TAG_W-1:0]  t2;
      logic [DATA_W-1:0] d2;
      logic [TAG_W-1:0]  t1;
      logic [DATA_W-1:0] d1;
      logic [OP_W-1:0]   op;
   } inst_s;

   logic              clk = 1'b0;
   logic              rst;
   logic              flush;
   logic              in_valid;
   logic [INST_W-1:0] in_inst;
   logic              in_ready;
   logic [7:0]        rs_free_state;
   logic              out_enable;
   logic [INST_W-1:0] out_inst;
   logic              lsb_cdb_valid;
   logic [TAG_W-1:0]  lsb_cdb_tag;
   logic [DATA_W-1:0] lsb_cdb_data;
   logic              alu_cdb_valid;
   logic [TAG_W-1:0]  alu_cdb_tag;
   logic [DATA_W-1:0] alu_cdb_data;
   logic [CNT_W-1:0]  count;

   int tests  = 0;
   int errors = 0;

   logic [INST_W-1:0] model_q [$];
   logic [INST_W-1:0] sb_q [$];

   alu_issue_queue dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_inst(in_inst), .in_ready(in_ready),
      .rs_free_state(rs_free_state),
      .out_enable(out_enable), .out_inst(out_inst),
      .lsb_cdb_valid(lsb_cdb_valid), .lsb_cdb_tag(lsb_cdb_tag), .lsb_cdb_data(lsb_cdb_data),
      .alu_cdb_valid(alu_cdb_valid), .alu_cdb_tag(alu_cdb_tag), .alu_cdb_data(alu_cdb_data),
      .count(count)
   );

   always #5 clk = ~clk;

   function automatic logic [INST_W-1:0] mk(input int dest, input int t2, input logic [31:0] d2,
                                             input int t1, input logic [31:0] d1, input int op);
      inst_s s;
      s.dest = TAG_W'(dest);
      s.t2   = TAG_W'(t2);
      s.d2   = d2;
      s.t1   = TAG_W'(t1);
      s.d1   = d1;
      s.op   = OP_W'(op);
      return s;
   endfunction

   // Operand resolution as the rules state it: a busy tag seen on a valid CDB
   // takes that CDB's data and becomes free; the LSB CDB is consulted first.
   function automatic logic [INST_W-1:0] resolve(input logic [INST_W-1:0] raw);
      inst_s s;
      s = raw;
      if (s.t1 != 0) begin
         if (lsb_cdb_valid && lsb_cdb_tag == s.t1)      begin s.d1 = lsb_cdb_data; s.t1 = 0; end
         else if (alu_cdb_valid && alu_cdb_tag == s.t1) begin s.d1 = alu_cdb_data; s.t1 = 0; end
      end
      if (s.t2 != 0) begin
         if (lsb_cdb_valid && lsb_cdb_tag == s.t2)      begin s.d2 = lsb_cdb_data; s.t2 = 0; end
         else if (alu_cdb_valid && alu_cdb_tag == s.t2) begin s.d2 = alu_cdb_data; s.t2 = 0; end
      end
      return s;
   endfunction

   // Reference model: evaluates the cycle's inputs, predicts outputs, then
   // advances its own queue as the coming clock edge would.
   always @(negedge clk) begin
      logic exp_en;
      logic exp_ready;
      logic cand;
      int   sz;
      sz        = model_q.size();
      cand      = in_valid && (in_inst[OP_W-1:0] != 0);
      exp_ready = (sz < DEPTH);
      exp_en    = 1'b0;
      if (!rst && !flush) exp_en = (rs_free_state != 8'hFF) && (sz > 0 || cand);

      tests++;
      if (out_enable !== exp_en) begin
         errors++;
         $display("FAIL out_enable: got %0b want %0b (t=%0t)", out_enable, exp_en, $time);
      end
      if (!rst) begin
         tests++;
         if (count !== CNT_W'(sz)) begin
            errors++;
            $display("FAIL count: got %0d want %0d (t=%0t)", count, sz, $time);
         end
         tests++;
         if (in_ready !== exp_ready) begin
            errors++;
            $display("FAIL in_ready: got %0b want %0b (t=%0t)", in_ready, exp_ready, $time);
         end
      end

      if (exp_en) sb_q.push_back(sz > 0 ? resolve(model_q[0]) : resolve(in_inst));

      if (rst || flush) begin
         model_q.delete();
      end else begin
         for (int i = 0; i < sz; i++) model_q[i] = resolve(model_q[i]);
         if (exp_en && sz > 0) void'(model_q.pop_front());
         if (cand && exp_ready && !(exp_en && sz == 0)) model_q.push_back(resolve(in_inst));
      end
   end

   // Monitor: whenever the DUT issues, pop the oldest prediction and compare.
   always @(negedge clk) begin
      logic [INST_W-1:0] exp_inst;
      #1;
      if (out_enable === 1'b1) begin
         tests++;
         if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL out_inst: got %h want <no issue expected> (t=%0t)", out_inst, $time);
         end else begin
            exp_inst = sb_q.pop_front();
            if (out_inst !== exp_inst) begin
               errors++;
               $display("FAIL out_inst: got %h want %h (t=%0t)", out_inst, exp_inst, $time);
            end else begin
               $display("[TB] issue %h (t=%0t)", out_inst, $time);
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      in_valid      = 1'b0;
      flush         = 1'b0;
      lsb_cdb_valid = 1'b0;
      alu_cdb_valid = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      in_inst = '0; rs_free_state = 8'h00;
      lsb_cdb_tag = '0; lsb_cdb_data = '0; alu_cdb_tag = '0; alu_cdb_data = '0;
      idle_inputs();
      step(); step();
      rst = 1'b0;
      step(); step();

      // Zero-latency bypass into a non-full RS
      in_valid = 1'b1; in_inst = mk(1, 0, 32'hA, 0, 32'hB, 3);
      step();
      idle_inputs(); step();

      // Fill while RS is full; entry 1 waits on tag 3; a 5th op is refused
      rs_free_state = 8'hFF;
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1; in_inst = mk(i + 2, 0, i, (i == 1) ? 3 : 0, 100 + i, i + 1);
         step();
      end
      in_inst = mk(9, 0, 5, 0, 5, 5);
      step();
      idle_inputs();
      alu_cdb_valid = 1'b1; alu_cdb_tag = 5'd3; alu_cdb_data = 32'hDEADBEEF;
      step();
      idle_inputs();
      rs_free_state = 8'h7F;
      repeat (6) step();

      // CDB forwarding during bypass, then dual-CDB priority
      rs_free_state = 8'h00;
      in_valid = 1'b1; in_inst = mk(3, 7, 32'h99, 0, 1, 2);
      lsb_cdb_valid = 1'b1; lsb_cdb_tag = 5'd7; lsb_cdb_data = 32'h12;
      step();
      in_inst = mk(4, 0, 0, 9, 5, 6);
      lsb_cdb_tag = 5'd9; lsb_cdb_data = 32'h1;
      alu_cdb_valid = 1'b1; alu_cdb_tag = 5'd9; alu_cdb_data = 32'h2;
      step();
      idle_inputs(); step();

      // Flush with three queued ops and a same-cycle push
      rs_free_state = 8'hFF;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1; in_inst = mk(i, 0, 32'h200 + i, 0, 0, 7); step();
      end
      flush = 1'b1; in_inst = mk(15, 0, 32'h77, 0, 0, 8);
      step();
      idle_inputs(); step(); step();

      // Wrap: hold two entries, then ten push/pop pairs
      for (int i = 0; i < 2; i++) begin
         in_valid = 1'b1; in_inst = mk(i, 0, 32'h300 + i, 0, 0, 9); step();
      end
      rs_free_state = 8'h00;
      for (int i = 0; i < 10; i++) begin
         in_valid = 1'b1; in_inst = mk(i + 2, 0, 32'h310 + i, 0, 0, 10); step();
      end
      idle_inputs();
      repeat (4) step();

      // Randomized traffic
      for (int n = 0; n < 400; n++) begin
         in_valid      = ($urandom_range(0, 3) != 0);
         in_inst       = mk($urandom_range(0, 31), $urandom_range(0, 3), $urandom,
                            $urandom_range(0, 3), $urandom,
                            ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 15));
         rs_free_state = ($urandom_range(0, 1) != 0) ? 8'hFF : 8'($urandom_range(0, 254));
         lsb_cdb_valid = ($urandom_range(0, 2) == 0);
         lsb_cdb_tag   = TAG_W'($urandom_range(1, 3));
         lsb_cdb_data  = $urandom;
         alu_cdb_valid = ($urandom_range(0, 2) == 0);
         alu_cdb_tag   = TAG_W'($urandom_range(1, 3));
         alu_cdb_data  = $urandom;
         flush         = ($urandom_range(0, 39) == 0);
         step();
      end

      // Drain
      idle_inputs();
      rs_free_state = 8'h00;
      repeat (8) step();

      tests++;
      if (sb_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d pending want 0", sb_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, errors);
      $finish;
   end

endmodule
